flash_dma_arbiter: RTL
======================

Name: flash_dma_arbiter

Overview:
- Multi-channel successor to the single-CPU flash read path.
- Accepts word read requests from CHANNELS independent requesters (e.g. CPU instruction fetch, CPU data, audio sample fetch) and arbitrates them round-robin onto one flash-controller valid/ready port.
- Adds sequential-read continuation: back-to-back consecutive addresses keep the flash transaction open, skipping command/address overhead.
- Sits between the bus requesters and the QSPI flash controller.

Parameters:
- CHANNELS, 2: number of requester channels (1..4).
- ADDR_WIDTH, 18: per-channel byte address width.
- FLASH_ADDR_WIDTH, 24: flash-side byte address width.
- FLASH_BASE, 24'h100000: user region base added to every request address.
- CONT_WINDOW, 4: maximum idle cycles after a completed read for which continuation is still offered.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- read_address  in  CHANNELS*ADDR_WIDTH  packed per-channel byte addresses; channel n at bits [n*ADDR_WIDTH +: ADDR_WIDTH]
- read_en  in  CHANNELS  per-channel request level; rising edge starts a read
- read_ready  out  CHANNELS  one-cycle completion pulse per channel
- read_data  out  32  data of the most recently completed read; valid while read_ready is high and held until the next completion
- flash_valid  out  1  request to the flash controller
- flash_addr  out  FLASH_ADDR_WIDTH  flash byte address
- flash_continue  out  1  request continues the previous sequential transfer
- flash_ready  in  1  flash controller completion strobe
- flash_rdata  in  32  flash controller read data
- busy  out  1  any channel pending or a transfer in flight

Behaviour:
- Reset (async): read_ready=0, flash_valid=0, flash_continue=0, read_data=0, busy=0, all pending bits clear, round-robin pointer=0, continuation invalid, FSM=IDLE.
- Reset asserted mid-transfer: flash_valid drops immediately and the in-flight result is discarded.
- Request capture:
  - read_en is registered once (read_en_r), then delayed once more (read_en_d).
  - The edge read_en_r & ~read_en_d sets pending[n] and latches that channel's address on the same edge.
  - An edge on a channel already pending is ignored. A request is one rising edge, not a level.
- FSM states:
  - IDLE: if any pending, grant the first pending channel at or after rr_ptr+1 (modulo CHANNELS).
    - Latch flash_addr = FLASH_BASE + zero-extended address. Addition wraps modulo 2^FLASH_ADDR_WIDTH.
    - Go to ISSUE.
  - ISSUE: flash_valid=1.
    - flash_continue=1 only if all three hold: flash_addr == last_addr+4 (wrapping), continuation valid, and idle counter <= CONT_WINDOW.
    - Hold flash_valid, flash_addr and flash_continue stable until flash_ready.
    - On flash_ready: read_data <= flash_rdata, last_addr <= flash_addr, continuation valid <= 1, idle counter <= 0, pending[grant] cleared, rr_ptr <= grant, go to DONE.
  - DONE: read_ready[grant] pulses for exactly one cycle, then return to IDLE.
- Latency:
  - Uncontended: read_en rise at cycle 0 gives pending at cycle 2, flash_valid at cycle 3.
  - read_ready follows flash_ready by 2 cycles.
- Continuation tracking:
  - The idle counter increments each cycle flash_valid=0, saturating at CONT_WINDOW+1.
  - Beyond CONT_WINDOW the continuation is invalid until the next completion.
- Simultaneous events:
  - An edge arriving in the same cycle pending is cleared for that channel sets pending again; it is not lost.
  - flash_ready while flash_valid=0 is ignored.
- busy = |pending | (state != IDLE).
- read_ready pulses of different channels never overlap.

Test Plan:
- Single channel 0, address 0x00010, flash_ready 5 cycles after flash_valid, rdata 0xDEADBEEF:
  - flash_addr=0x100010, flash_continue=0.
  - read_ready[0] pulses once, 2 cycles after flash_ready.
  - read_data=0xDEADBEEF.
- Channel 0 reads 0x00010 then, 2 idle cycles later, 0x00014 -> second request flash_continue=1, flash_addr=0x100014. Repeat with 8 idle cycles -> flash_continue=0.
- Channels 0 and 1 raise read_en in the same cycle -> channel 1 is granted first (rr_ptr=0 after reset), then channel 0. Pulses appear in that order and never overlap.
- read_en held high for 20 cycles on channel 1 -> exactly one flash transfer and one read_ready[1] pulse.
- Async reset asserted while flash_valid=1 -> flash_valid=0 the same cycle, busy=0. No read_ready pulse after reset release without a new edge.
- Address 0x3FFFC with FLASH_BASE=24'hFFFFF0 -> flash_addr=24'h03FFEC (wrap).

Source files
------------

// File: rtl/flash_dma_arbiter.sv
// flash_dma_arbiter: round-robin arbiter of per-channel word reads onto one flash port,
// with sequential-read continuation when consecutive addresses arrive within a short window.
module flash_dma_arbiter #(
  parameter int CHANNELS = 2,
  parameter int ADDR_WIDTH = 18,
  parameter int FLASH_ADDR_WIDTH = 24,
  parameter logic [FLASH_ADDR_WIDTH-1:0] FLASH_BASE = 24'h100000,
  parameter int CONT_WINDOW = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CHANNELS*ADDR_WIDTH-1:0]   read_address,
  input  logic [CHANNELS-1:0]              read_en,
  output logic [CHANNELS-1:0]              read_ready,
  output logic [31:0]                      read_data,
  output logic                             flash_valid,
  output logic [FLASH_ADDR_WIDTH-1:0]      flash_addr,
  output logic                             flash_continue,
  input  logic                             flash_ready,
  input  logic [31:0]                      flash_rdata,
  output logic                             busy
);
  localparam int PW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int CW = $clog2(CONT_WINDOW + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(CONT_WINDOW + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_n;
  logic [CHANNELS-1:0] read_en_r, read_en_d, edge_det, pending, clr;
  logic [CHANNELS*ADDR_WIDTH-1:0] addr_q;
  logic [PW-1:0] rr_ptr, grant, pick;
  logic found, done, cont_valid;
  logic [FLASH_ADDR_WIDTH-1:0] last_addr;
  logic [CW-1:0] idle_cnt;
  assign edge_det = read_en_r & ~read_en_d;
  assign flash_valid = state == ISSUE;
  assign done = flash_valid & flash_ready;
  assign clr = done ? CHANNELS'(1) << grant : '0;
  assign busy = |pending | (state != IDLE);
  assign flash_continue = flash_valid && cont_valid && idle_cnt <= CW'(CONT_WINDOW)
                          && flash_addr == last_addr + FLASH_ADDR_WIDTH'(4);
  // first pending channel strictly after the last served one, wrapping around
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!found && pending[(int'(rr_ptr) + i) % CHANNELS]) begin
        found = 1'b1;
        pick = PW'((int'(rr_ptr) + i) % CHANNELS);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_en_r <= '0;
      read_en_d <= '0;
      pending <= '0;
      addr_q <= '0;
    end else begin
      read_en_r <= read_en;
      read_en_d <= read_en_r;
      pending <= (pending & ~clr) | edge_det;
      for (int n = 0; n < CHANNELS; n++)
        if (edge_det[n] && (!pending[n] || clr[n]))
          addr_q[n*ADDR_WIDTH +: ADDR_WIDTH] <= read_address[n*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && found) state_n = ISSUE;
    else if (done) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_ready <= '0;
      read_data <= '0;
      flash_addr <= '0;
      grant <= '0;
      rr_ptr <= '0;
      last_addr <= '0;
      cont_valid <= 1'b0;
      idle_cnt <= CNT_MAX;
    end else begin
      read_ready <= state == DONE ? CHANNELS'(1) << grant : '0;
      if (state == IDLE && found) begin
        grant <= pick;
        flash_addr <= FLASH_BASE + FLASH_ADDR_WIDTH'(addr_q[pick*ADDR_WIDTH +: ADDR_WIDTH]);
      end
      if (done) begin
        read_data <= flash_rdata;
        last_addr <= flash_addr;
        cont_valid <= 1'b1;
        idle_cnt <= '0;
        rr_ptr <= grant;
      end else if (!flash_valid && idle_cnt != CNT_MAX) begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end
endmodule
